// File: rtl/dev_bridge.sv
// ============================================================================
//  Module   : dev_bridge
//  Purpose  : CPU-side initiator for the Addr[3:2]/WE/WD/RD/IRQ device
//             register interface. Takes one CPU load/store at a time,
//             decodes it to device 0, device 1 or (optionally) the bridge
//             IRQ status word, drives the device port for one cycle and
//             returns read data or a decode error. Also gathers device IRQ
//             lines into the CPU HWInt vector.
//  Ports    : clk_i, rst_i (async, active-high)
//             req_i, addr_i[31:0], we_i, wd_i[31:0]      CPU request
//             ready_o, rd_o[31:0], err_o                 CPU response
//             dev0_addr_o[1:0], dev0_we_o                device 0 select
//             dev1_addr_o[1:0], dev1_we_o                device 1 select
//             dev_wd_o[31:0]                             shared write data
//             dev0_rd_i, dev1_rd_i [31:0]                device read data
//             dev0_irq_i, dev1_irq_i                     device IRQ levels
//             hwint_o[5:0]                               CPU interrupt vector
//  Config   : define IRQ_LATCH_EN to latch IRQ rising edges into a
//             write-1-to-clear pending register readable at BRIDGE_BASE.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module dev_bridge #(
  parameter logic [31:0] DEV0_BASE   = 32'h0000_7F00,
  parameter logic [31:0] DEV1_BASE   = 32'h0000_7F10,
  parameter logic [31:0] BRIDGE_BASE = 32'h0000_7F20
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic [31:0] addr_i,
  input  logic        we_i,
  input  logic [31:0] wd_i,
  output logic        ready_o,
  output logic [31:0] rd_o,
  output logic        err_o,
  output logic [1:0]  dev0_addr_o,
  output logic        dev0_we_o,
  output logic [1:0]  dev1_addr_o,
  output logic        dev1_we_o,
  output logic [31:0] dev_wd_o,
  input  logic [31:0] dev0_rd_i,
  input  logic [31:0] dev1_rd_i,
  input  logic        dev0_irq_i,
  input  logic        dev1_irq_i,
  output logic [5:0]  hwint_o
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        we_q, we_d;
  logic        hit0_q, hit0_d;
  logic        hit1_q, hit1_d;
  logic        hitb_q, hitb_d;
  logic        ready_q, ready_d;
  logic        err_q, err_d;
  logic [31:0] rd_q, rd_d;
  logic [1:0]  dev0_addr_q, dev0_addr_d;
  logic        dev0_we_q, dev0_we_d;
  logic [1:0]  dev1_addr_q, dev1_addr_d;
  logic        dev1_we_q, dev1_we_d;
  logic [31:0] dev_wd_q, dev_wd_d;
  logic [1:0]  irq_view;   // value returned by a bridge-word read / shown on HWInt

  // Address decode on the incoming request; word 3 of each device is a hole.
  logic hit0_w, hit1_w, hitb_w;
  assign hit0_w = (addr_i[31:4] == DEV0_BASE[31:4]) && (addr_i[3:2] != 2'b11);
  assign hit1_w = (addr_i[31:4] == DEV1_BASE[31:4]) && (addr_i[3:2] != 2'b11);

`ifdef IRQ_LATCH_EN
  logic [1:0] irq_prev_q;
  logic [1:0] pending_q, pending_d;
  logic [1:0] irq_rise;
  logic [1:0] irq_clr;

  // Only the single word at BRIDGE_BASE decodes; +4/+8 fall through to a miss.
  assign hitb_w = (addr_i[31:2] == BRIDGE_BASE[31:2]);

  assign irq_rise = {dev1_irq_i, dev0_irq_i} & ~irq_prev_q;
  assign irq_clr  = (state_q == S_ACCESS && hitb_q && we_q) ? dev_wd_q[1:0] : 2'b00;
  // Set is ORed in after the clear so a same-cycle edge is never lost.
  assign pending_d = (pending_q & ~irq_clr) | irq_rise;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      irq_prev_q <= 2'b00;
      pending_q  <= 2'b00;
    end else begin
      irq_prev_q <= {dev1_irq_i, dev0_irq_i};
      pending_q  <= pending_d;
    end
  end

  assign irq_view = pending_q;

  logic unused_w;
  assign unused_w = ^addr_i[1:0];
`else
  logic [1:0] irq_q;

  assign hitb_w = 1'b0;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      irq_q <= 2'b00;
    end else begin
      irq_q <= {dev1_irq_i, dev0_irq_i};
    end
  end

  assign irq_view = irq_q;

  logic unused_w;
  assign unused_w = ^{addr_i[1:0], BRIDGE_BASE};
`endif

  // Next-state and output logic. Device select outputs default to 0 so they
  // are only non-zero during the single ACCESS cycle.
  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    hit0_d      = hit0_q;
    hit1_d      = hit1_q;
    hitb_d      = hitb_q;
    dev_wd_d    = dev_wd_q;
    ready_d     = 1'b0;
    err_d       = 1'b0;
    rd_d        = 32'h0;
    dev0_addr_d = 2'b00;
    dev0_we_d   = 1'b0;
    dev1_addr_d = 2'b00;
    dev1_we_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req_i) begin
          state_d     = S_ACCESS;
          we_d        = we_i;
          hit0_d      = hit0_w;
          hit1_d      = hit1_w;
          hitb_d      = hitb_w;
          dev_wd_d    = wd_i;
          dev0_addr_d = hit0_w ? addr_i[3:2] : 2'b00;
          dev0_we_d   = hit0_w & we_i;
          dev1_addr_d = hit1_w ? addr_i[3:2] : 2'b00;
          dev1_we_d   = hit1_w & we_i;
        end
      end
      S_ACCESS: begin
        state_d = S_RESP;
        ready_d = 1'b1;
        err_d   = ~(hit0_q | hit1_q | hitb_q);
        // Device read data is combinational on the held select, so it is
        // captured here at the end of ACCESS.
        if (!we_q) begin
          if (hit0_q) begin
            rd_d = dev0_rd_i;
          end else if (hit1_q) begin
            rd_d = dev1_rd_i;
          end else if (hitb_q) begin
            rd_d = {30'h0, irq_view};
          end
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      we_q        <= 1'b0;
      hit0_q      <= 1'b0;
      hit1_q      <= 1'b0;
      hitb_q      <= 1'b0;
      ready_q     <= 1'b0;
      err_q       <= 1'b0;
      rd_q        <= 32'h0;
      dev0_addr_q <= 2'b00;
      dev0_we_q   <= 1'b0;
      dev1_addr_q <= 2'b00;
      dev1_we_q   <= 1'b0;
      dev_wd_q    <= 32'h0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      hit0_q      <= hit0_d;
      hit1_q      <= hit1_d;
      hitb_q      <= hitb_d;
      ready_q     <= ready_d;
      err_q       <= err_d;
      rd_q        <= rd_d;
      dev0_addr_q <= dev0_addr_d;
      dev0_we_q   <= dev0_we_d;
      dev1_addr_q <= dev1_addr_d;
      dev1_we_q   <= dev1_we_d;
      dev_wd_q    <= dev_wd_d;
    end
  end

  assign ready_o     = ready_q;
  assign rd_o        = rd_q;
  assign err_o       = err_q;
  assign dev0_addr_o = dev0_addr_q;
  assign dev0_we_o   = dev0_we_q;
  assign dev1_addr_o = dev1_addr_q;
  assign dev1_we_o   = dev1_we_q;
  assign dev_wd_o    = dev_wd_q;
  assign hwint_o     = {4'b0000, irq_view};

endmodule

`default_nettype wire

// File: tb/tb_dev_bridge.sv
// ============================================================================
//  Module   : tb_dev_bridge
//  Purpose  : Directed self-checking bench for dev_bridge.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_dev_bridge;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        req_i = 1'b0;
  logic [31:0] addr_i = 32'h0;
  logic        we_i = 1'b0;
  logic [31:0] wd_i = 32'h0;
  logic        ready_o;
  logic [31:0] rd_o;
  logic        err_o;
  logic [1:0]  dev0_addr_o;
  logic        dev0_we_o;
  logic [1:0]  dev1_addr_o;
  logic        dev1_we_o;
  logic [31:0] dev_wd_o;
  logic [31:0] dev0_rd_i = 32'h0;
  logic [31:0] dev1_rd_i = 32'h0;
  logic        dev0_irq_i = 1'b0;
  logic        dev1_irq_i = 1'b0;
  logic [5:0]  hwint_o;

  int errors = 0;
  int checks = 0;

  dev_bridge dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .req_i       (req_i),
    .addr_i      (addr_i),
    .we_i        (we_i),
    .wd_i        (wd_i),
    .ready_o     (ready_o),
    .rd_o        (rd_o),
    .err_o       (err_o),
    .dev0_addr_o (dev0_addr_o),
    .dev0_we_o   (dev0_we_o),
    .dev1_addr_o (dev1_addr_o),
    .dev1_we_o   (dev1_we_o),
    .dev_wd_o    (dev_wd_o),
    .dev0_rd_i   (dev0_rd_i),
    .dev1_rd_i   (dev1_rd_i),
    .dev0_irq_i  (dev0_irq_i),
    .dev1_irq_i  (dev1_irq_i),
    .hwint_o     (hwint_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Present a one-cycle request; returns in the ACCESS cycle.
  task automatic issue(input logic [31:0] a, input logic w, input logic [31:0] d);
    addr_i = a;
    we_i   = w;
    wd_i   = d;
    req_i  = 1'b1;
    step();
    req_i  = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".ready"}, {31'h0, ready_o}, 32'h0);
    chk({tag, ".rd"}, rd_o, 32'h0);
    chk({tag, ".err"}, {31'h0, err_o}, 32'h0);
    chk({tag, ".d0"}, {29'h0, dev0_we_o, dev0_addr_o}, 32'h0);
    chk({tag, ".d1"}, {29'h0, dev1_we_o, dev1_addr_o}, 32'h0);
    chk({tag, ".wd"}, dev_wd_o, 32'h0);
    chk({tag, ".hwint"}, {26'h0, hwint_o}, 32'h0);
  endtask

  initial begin
    // ---------------- reset state ----------------
    #2 rst_i = 1'b1;
    #1 chk_all_zero("reset");
    step();
    rst_i = 1'b0;
    step();
    chk("idle.ready", {31'h0, ready_o}, 32'h0);

    // ---------------- write dev0 word 1 ----------------
    issue(32'h0000_7F04, 1'b1, 32'h5);
    chk("wr0.we0",   {31'h0, dev0_we_o}, 32'h1);
    chk("wr0.addr0", {30'h0, dev0_addr_o}, 32'h1);
    chk("wr0.wd",    dev_wd_o, 32'h5);
    chk("wr0.we1",   {31'h0, dev1_we_o}, 32'h0);
    chk("wr0.addr1", {30'h0, dev1_addr_o}, 32'h0);
    chk("wr0.rdyA",  {31'h0, ready_o}, 32'h0);
    step();
    chk("wr0.ready", {31'h0, ready_o}, 32'h1);
    chk("wr0.err",   {31'h0, err_o}, 32'h0);
    chk("wr0.rd",    rd_o, 32'h0);
    chk("wr0.weR",   {31'h0, dev0_we_o}, 32'h0);
    chk("wr0.adR",   {30'h0, dev0_addr_o}, 32'h0);
    step();
    chk("wr0.rdyI",  {31'h0, ready_o}, 32'h0);

    // ---------------- read dev1 word 2 ----------------
    dev0_rd_i = 32'hDEAD_0000;
    dev1_rd_i = 32'h0000_1234;
    issue(32'h0000_7F18, 1'b0, 32'hFFFF_FFFF);
    chk("rd1.addr1", {30'h0, dev1_addr_o}, 32'h2);
    chk("rd1.we1",   {31'h0, dev1_we_o}, 32'h0);
    chk("rd1.addr0", {30'h0, dev0_addr_o}, 32'h0);
    step();
    chk("rd1.ready", {31'h0, ready_o}, 32'h1);
    chk("rd1.rd",    rd_o, 32'h0000_1234);
    chk("rd1.err",   {31'h0, err_o}, 32'h0);
    step();

    // ---------------- read dev0 word 2 ----------------
    dev0_rd_i = 32'h0000_CAFE;
    issue(32'h0000_7F08, 1'b0, 32'h0);
    chk("rd0.addr0", {30'h0, dev0_addr_o}, 32'h2);
    step();
    chk("rd0.rd",    rd_o, 32'h0000_CAFE);
    chk("rd0.err",   {31'h0, err_o}, 32'h0);
    step();

    // ---------------- misses ----------------
    issue(32'h0000_7F0C, 1'b1, 32'h7);
    chk("mw.we", {30'h0, dev1_we_o, dev0_we_o}, 32'h0);
    step();
    chk("mw.ready", {31'h0, ready_o}, 32'h1);
    chk("mw.err",   {31'h0, err_o}, 32'h1);
    chk("mw.rd",    rd_o, 32'h0);
    step();
    issue(32'h0000_7F30, 1'b0, 32'h0);
    chk("mr.we", {30'h0, dev1_we_o, dev0_we_o}, 32'h0);
    step();
    chk("mr.err", {31'h0, err_o}, 32'h1);
    chk("mr.rd",  rd_o, 32'h0);
    step();
    issue(32'h0000_7F24, 1'b0, 32'h0);
    step();
    chk("mb4.err", {31'h0, err_o}, 32'h1);
    step();

    // ---------------- Req ignored while busy ----------------
    issue(32'h0000_7F14, 1'b1, 32'h9);
    req_i = 1'b1;        // stray request during ACCESS
    step();
    req_i = 1'b0;
    chk("busy.ready", {31'h0, ready_o}, 32'h1);
    step();
    chk("busy.idle1", {30'h0, ready_o, dev1_we_o}, 32'h0);
    step();
    chk("busy.idle2", {30'h0, ready_o, dev1_we_o}, 32'h0);

    // ---------------- reset during RESP ----------------
    dev1_rd_i = 32'h0000_5555;
    issue(32'h0000_7F10, 1'b0, 32'h0);
    step();
    chk("rr.ready", {31'h0, ready_o}, 32'h1);
    rst_i = 1'b1;
    #1 chk_all_zero("rstresp");
    step();
    rst_i = 1'b0;
    step();
    chk("rr.after", {31'h0, ready_o}, 32'h0);
    step();
    chk("rr.after2", {31'h0, ready_o}, 32'h0);

    // ---------------- reset during write ACCESS ----------------
    issue(32'h0000_7F00, 1'b1, 32'hA5);
    chk("ra.we0", {31'h0, dev0_we_o}, 32'h1);
    #2 rst_i = 1'b1;
    #1 chk_all_zero("rstacc");
    step();
    rst_i = 1'b0;
    step();
    chk("ra.noready1", {31'h0, ready_o}, 32'h0);
    step();
    chk("ra.noready2", {31'h0, ready_o}, 32'h0);
    issue(32'h0000_7F14, 1'b1, 32'h3C);
    chk("ra.next.we1", {31'h0, dev1_we_o}, 32'h1);
    chk("ra.next.a1",  {30'h0, dev1_addr_o}, 32'h1);
    chk("ra.next.wd",  dev_wd_o, 32'h3C);
    step();
    chk("ra.next.rdy", {31'h0, ready_o}, 32'h1);
    chk("ra.next.err", {31'h0, err_o}, 32'h0);
    step();

`ifdef IRQ_LATCH_EN
    // ---------------- latched IRQ ----------------
    chk("li.init", {26'h0, hwint_o}, 32'h0);
    dev0_irq_i = 1'b1;
    step();
    dev0_irq_i = 1'b0;
    chk("li.set", {26'h0, hwint_o}, 32'h01);
    step();
    step();
    chk("li.held", {26'h0, hwint_o}, 32'h01);
    issue(32'h0000_7F20, 1'b0, 32'h0);
    step();
    chk("li.rd",  rd_o, 32'h1);
    chk("li.err", {31'h0, err_o}, 32'h0);
    step();
    issue(32'h0000_7F20, 1'b1, 32'h1);
    step();
    chk("li.clr", {26'h0, hwint_o}, 32'h0);
    chk("li.werr", {31'h0, err_o}, 32'h0);
    step();
    dev0_irq_i = 1'b1;
    step();
    dev0_irq_i = 1'b0;
    chk("li.set2", {26'h0, hwint_o}, 32'h01);
    step();
    issue(32'h0000_7F20, 1'b1, 32'h1);
    dev0_irq_i = 1'b1;   // rising edge in the clear cycle
    step();
    dev0_irq_i = 1'b0;
    chk("li.setwins", {26'h0, hwint_o}, 32'h01);
    step();
    issue(32'h0000_7F28, 1'b0, 32'h0);
    step();
    chk("li.b8miss", {31'h0, err_o}, 32'h1);
    step();
`else
    // ---------------- registered IRQ pass-through ----------------
    issue(32'h0000_7F20, 1'b0, 32'h0);
    step();
    chk("bb.err", {31'h0, err_o}, 32'h1);
    chk("bb.rd",  rd_o, 32'h0);
    step();
    dev0_irq_i = 1'b1;
    #2 chk("irq.lag", {26'h0, hwint_o}, 32'h0);
    step();
    chk("irq.d0", {26'h0, hwint_o}, 32'h01);
    dev1_irq_i = 1'b1;
    step();
    chk("irq.both", {26'h0, hwint_o}, 32'h03);
    dev0_irq_i = 1'b0;
    step();
    chk("irq.d1", {26'h0, hwint_o}, 32'h02);
    dev1_irq_i = 1'b0;
    step();
    chk("irq.none", {26'h0, hwint_o}, 32'h00);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
